// File: rtl/disaggregator_pkg.sv
// Shared types and helpers for the disaggregator.
// Lane select and fetch-width clamp used by the datapath.
package disagg_pkg;
    localparam int DATA_WIDTH  = 8;
    localparam int FETCH_WIDTH = 6;
    localparam int FW_BITS     = $clog2(FETCH_WIDTH + 1);
    localparam int WORD_W      = DATA_WIDTH * FETCH_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] lane(input logic [WORD_W-1:0]  word,
                                                   input logic [FW_BITS-1:0] idx);
        logic [DATA_WIDTH-1:0] sel;
        sel = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (idx == FW_BITS'(i)) sel = word[i*DATA_WIDTH +: DATA_WIDTH];
        end
        return sel;
    endfunction

    // Zero or anything wider than the word means "all lanes".
    function automatic logic [FW_BITS-1:0] clamp_width(input logic [FW_BITS-1:0] w);
        if (w == '0 || w > FW_BITS'(FETCH_WIDTH)) return FW_BITS'(FETCH_WIDTH);
        return w;
    endfunction
endpackage

// File: rtl/disaggregator_if.sv
// Wide-in / narrow-out FIFO handshake bundle plus the fetch-width control pair.
interface disagg_if;
    import disagg_pkg::*;

    logic [WORD_W-1:0]     sender_data;
    logic                  sender_empty_n;
    logic                  sender_deq;
    logic [DATA_WIDTH-1:0] receiver_data;
    logic                  receiver_full_n;
    logic                  receiver_enq;
    logic                  change_fetch_width;
    logic [FW_BITS-1:0]    input_fetch_width;

    modport slave (
        input  sender_data, sender_empty_n, receiver_full_n,
        input  change_fetch_width, input_fetch_width,
        output sender_deq, receiver_data, receiver_enq
    );

    modport master (
        output sender_data, sender_empty_n, receiver_full_n,
        output change_fetch_width, input_fetch_width,
        input  sender_deq, receiver_data, receiver_enq
    );
endinterface

// File: rtl/disaggregator.sv
// Splits one wide FWFT word into width_active narrow words, lane 0 first; 1 cycle deq->first enq.
// Stalls on receiver_full_n low; next word is popped on the last lane's fire with no bubble.
module disaggregator
    import disagg_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    disagg_if.slave bus
);
    state_t                r_state;
    state_t                w_state_nxt;
    logic [WORD_W-1:0]     r_word;
    logic [FW_BITS-1:0]    r_idx;
    logic [FW_BITS-1:0]    r_width;
    logic [FW_BITS-1:0]    r_pend_w;
    logic                  r_pend_vld;
    logic [DATA_WIDTH-1:0] r_hold;

    logic                  w_fire;
    logic                  w_last_fire;
    logic                  w_load;
    logic                  w_apply;
    logic [DATA_WIDTH-1:0] w_lane;

    assign w_lane      = lane(r_word, r_idx);
    assign w_fire      = (r_state == SEND) && bus.receiver_full_n;
    assign w_last_fire = w_fire && (r_idx == r_width - FW_BITS'(1));
    // rst_n gate keeps the pop quiet while the register state is forced.
    assign w_load      = rst_n && bus.sender_empty_n && ((r_state == IDLE) || w_last_fire);
    assign w_apply     = w_load || (r_state == IDLE);

    assign bus.sender_deq    = w_load;
    assign bus.receiver_enq  = w_fire;
    assign bus.receiver_data = (r_state == SEND) ? w_lane : r_hold;

    always_comb begin
        w_state_nxt = r_state;
        if (w_load)
            w_state_nxt = SEND;
        else if (w_last_fire)
            w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_idx      <= '0;
            r_width    <= FW_BITS'(FETCH_WIDTH);
            r_pend_w   <= '0;
            r_pend_vld <= 1'b0;
            r_hold     <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_load) begin
                r_word <= bus.sender_data;
                r_idx  <= '0;
            end else if (w_last_fire) begin
                r_idx  <= '0;
            end else if (w_fire) begin
                r_idx  <= r_idx + FW_BITS'(1);
            end

            if (w_fire) r_hold <= w_lane;

            // A request arriving with a load is kept for the following word.
            if (w_apply && r_pend_vld) r_width <= r_pend_w;

            if (bus.change_fetch_width) begin
                r_pend_w   <= clamp_width(bus.input_fetch_width);
                r_pend_vld <= 1'b1;
            end else if (w_apply) begin
                r_pend_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_disaggregator.sv
// Bench for disaggregator: queue-based wide FIFO source, narrow sink, lane-expansion reference model.
module tb_disaggregator;
    import disagg_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    disagg_if bus();

    disaggregator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [WORD_W-1:0]     wq[$];
    logic [DATA_WIDTH-1:0] exp_q[$];
    logic [DATA_WIDTH-1:0] obs[$];
    int                    obs_cyc[$];
    int                    deq_cyc[$];
    int                    cyc      = 0;
    int                    viol     = 0;
    int                    n_checks = 0;
    int                    n_pass   = 0;

    function automatic logic [WORD_W-1:0] mk_word(input int base);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) w[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(base + i);
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] rnd_word();
        logic [WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) w[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
        return w;
    endfunction

    // Reference: a word under requested width n yields lanes 0..n-1 (0 or >FETCH_WIDTH means all).
    function automatic void model_word(input logic [WORD_W-1:0] w, input int req);
        int n;
        n = (req == 0 || req > FETCH_WIDTH) ? FETCH_WIDTH : req;
        for (int i = 0; i < n; i++) exp_q.push_back(w[i*DATA_WIDTH +: DATA_WIDTH]);
    endfunction

    task automatic clear_logs();
        obs.delete();
        exp_q.delete();
        obs_cyc.delete();
        deq_cyc.delete();
        viol = 0;
    endtask

    task automatic run_cycle(input bit chg, input logic [FW_BITS-1:0] fw, input int pct);
        @(negedge clk);
        bus.sender_empty_n     = (wq.size() > 0);
        bus.sender_data        = (wq.size() > 0) ? wq[0] : '0;
        bus.receiver_full_n    = ($urandom_range(99) < pct);
        bus.change_fetch_width = chg;
        bus.input_fetch_width  = fw;
        #1;
        if (bus.receiver_enq) begin
            obs.push_back(bus.receiver_data);
            obs_cyc.push_back(cyc);
            if (!bus.receiver_full_n) viol++;
        end
        if (bus.sender_deq) begin
            if (wq.size() == 0) viol++;
            else void'(wq.pop_front());
            deq_cyc.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic drain(input int budget, input int pct);
        int n;
        n = 0;
        while ((wq.size() > 0 || obs.size() < exp_q.size()) && n < budget) begin
            run_cycle(1'b0, '0, pct);
            n++;
        end
        repeat (4) run_cycle(1'b0, '0, 100);
    endtask

    task automatic test_reset();
        rst_n                  = 1'b0;
        bus.sender_empty_n     = 1'b1;
        bus.sender_data        = mk_word(8'h40);
        bus.receiver_full_n    = 1'b1;
        bus.change_fetch_width = 1'b0;
        bus.input_fetch_width  = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (bus.sender_deq !== 1'b0) $display("FAIL reset_deq: got %b want 0", bus.sender_deq); else n_pass++;
        n_checks++; if (bus.receiver_enq !== 1'b0) $display("FAIL reset_enq: got %b want 0", bus.receiver_enq); else n_pass++;
        n_checks++; if (bus.receiver_data !== '0) $display("FAIL reset_data: got %0h want 0", bus.receiver_data); else n_pass++;
        bus.sender_empty_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_default();
        logic [WORD_W-1:0] w;
        clear_logs();
        w = mk_word(8'h10);
        wq.push_back(w);
        model_word(w, 6);
        drain(50, 100);
        n_checks++; if (obs.size() !== exp_q.size()) $display("FAIL default_count: got %0d want %0d", obs.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++; if (obs[i] !== exp_q[i]) $display("FAIL default_lane%0d: got %0h want %0h", i, obs[i], exp_q[i]); else n_pass++;
            n_checks++; if (obs_cyc[i] !== obs_cyc[0] + i) $display("FAIL default_gap%0d: got cycle %0d want %0d", i, obs_cyc[i], obs_cyc[0] + i); else n_pass++;
        end
        n_checks++; if (deq_cyc.size() !== 1) $display("FAIL default_deqs: got %0d want 1", deq_cyc.size()); else n_pass++;
        if (deq_cyc.size() > 0 && obs_cyc.size() > 0) begin
            n_checks++; if (obs_cyc[0] !== deq_cyc[0] + 1) $display("FAIL default_latency: got %0d want %0d", obs_cyc[0] - deq_cyc[0], 1); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [WORD_W-1:0] a, b;
        clear_logs();
        run_cycle(1'b1, 3'd4, 100);
        a = mk_word(1);
        b = mk_word(7);
        wq.push_back(a); wq.push_back(b);
        model_word(a, 4); model_word(b, 4);
        drain(50, 100);
        n_checks++; if (obs.size() !== exp_q.size()) $display("FAIL b2b_count: got %0d want %0d", obs.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++; if (obs[i] !== exp_q[i]) $display("FAIL b2b_lane%0d: got %0h want %0h", i, obs[i], exp_q[i]); else n_pass++;
            n_checks++; if (obs_cyc[i] !== obs_cyc[0] + i) $display("FAIL b2b_bubble%0d: got cycle %0d want %0d", i, obs_cyc[i], obs_cyc[0] + i); else n_pass++;
        end
        n_checks++; if (deq_cyc.size() !== 2) $display("FAIL b2b_deqs: got %0d want 2", deq_cyc.size()); else n_pass++;
    endtask

    task automatic test_random_backpressure();
        logic [WORD_W-1:0] w;
        clear_logs();
        run_cycle(1'b1, 3'd6, 100);
        for (int k = 0; k < 10; k++) begin
            w = mk_word(k * 6);
            wq.push_back(w);
            model_word(w, 6);
        end
        drain(800, 50);
        n_checks++; if (obs.size() !== exp_q.size()) $display("FAIL rand_count: got %0d want %0d", obs.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++; if (obs[i] !== exp_q[i]) $display("FAIL rand_word%0d: got %0h want %0h", i, obs[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (viol !== 0) $display("FAIL rand_protocol: got %0d violations want 0", viol); else n_pass++;
        n_checks++; if (deq_cyc.size() !== 10) $display("FAIL rand_deqs: got %0d want 10", deq_cyc.size()); else n_pass++;
    endtask

    task automatic test_midword_change();
        logic [WORD_W-1:0] a, b, c;
        bit sent, chg;
        int n;
        clear_logs();
        run_cycle(1'b1, 3'd4, 100);
        a = rnd_word(); b = rnd_word(); c = rnd_word();
        wq.push_back(a); wq.push_back(b); wq.push_back(c);
        model_word(a, 4); model_word(b, 1); model_word(c, 1);
        sent = 1'b0;
        n = 0;
        while ((wq.size() > 0 || obs.size() < exp_q.size()) && n < 60) begin
            chg = (obs.size() == 2) && !sent;
            if (chg) sent = 1'b1;
            run_cycle(chg, 3'd1, 100);
            n++;
        end
        repeat (4) run_cycle(1'b0, '0, 100);
        n_checks++; if (obs.size() !== exp_q.size()) $display("FAIL mid_count: got %0d want %0d", obs.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++; if (obs[i] !== exp_q[i]) $display("FAIL mid_word%0d: got %0h want %0h", i, obs[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (deq_cyc.size() !== 3) $display("FAIL mid_deqs: got %0d want 3", deq_cyc.size()); else n_pass++;
    endtask

    task automatic test_clamp();
        logic [WORD_W-1:0] w0, w7;
        clear_logs();
        run_cycle(1'b1, 3'd0, 100);
        w0 = rnd_word();
        wq.push_back(w0);
        model_word(w0, 0);
        drain(50, 100);
        run_cycle(1'b1, 3'd3, 100);
        run_cycle(1'b1, 3'd7, 100);
        w7 = rnd_word();
        wq.push_back(w7);
        model_word(w7, 7);
        drain(50, 100);
        n_checks++; if (obs.size() !== exp_q.size()) $display("FAIL clamp_count: got %0d want %0d", obs.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++; if (obs[i] !== exp_q[i]) $display("FAIL clamp_word%0d: got %0h want %0h", i, obs[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_midword();
        logic [WORD_W-1:0] w1, w2;
        bit sent, chg;
        int n;
        clear_logs();
        run_cycle(1'b1, 3'd6, 100);
        w1 = mk_word(8'h80);
        w2 = mk_word(8'hA0);
        wq.push_back(w1); wq.push_back(w2);
        sent = 1'b0;
        n = 0;
        while (obs.size() < 3 && n < 40) begin
            chg = (obs.size() == 1) && !sent;
            if (chg) sent = 1'b1;
            run_cycle(chg, 3'd2, 100);
            n++;
        end
        model_word(w1, 3);
        n_checks++; if (obs.size() !== 3) $display("FAIL rstmid_pre_count: got %0d want 3", obs.size()); else n_pass++;
        for (int i = 0; i < 3 && i < obs.size(); i++) begin
            n_checks++; if (obs[i] !== exp_q[i]) $display("FAIL rstmid_pre%0d: got %0h want %0h", i, obs[i], exp_q[i]); else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.sender_deq !== 1'b0) $display("FAIL rstmid_deq: got %b want 0", bus.sender_deq); else n_pass++;
        n_checks++; if (bus.receiver_enq !== 1'b0) $display("FAIL rstmid_enq: got %b want 0", bus.receiver_enq); else n_pass++;
        n_checks++; if (bus.receiver_data !== '0) $display("FAIL rstmid_data: got %0h want 0", bus.receiver_data); else n_pass++;
        bus.sender_empty_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        model_word(w2, 6);
        drain(50, 100);
        n_checks++; if (obs.size() !== exp_q.size()) $display("FAIL rstmid_count: got %0d want %0d", obs.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_checks++; if (obs[i] !== exp_q[i]) $display("FAIL rstmid_word%0d: got %0h want %0h", i, obs[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (deq_cyc.size() !== 1) $display("FAIL rstmid_deqs: got %0d want 1", deq_cyc.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_default();
        test_back_to_back();
        test_random_backpressure();
        test_midword_change();
        test_clamp();
        test_reset_midword();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
